// File: rtl/inference_frame_buffer.sv
// ---------------------------------------------------------------------------
// inference_frame_buffer
//
// Captures complete inference frames from the IP receive stage (whose
// DATA_FRAME register is overwritten by the next packet) and presents them to
// the accelerator core through a valid/ready FIFO of DEPTH entries.
//
// Handshake: OUT_VALID is high whenever the head entry holds a frame; a frame
// is consumed on a rising ACLK edge where OUT_VALID && OUT_READY. While
// OUT_VALID=1 and OUT_READY=0 all OUT_* hold stable, and OUT_VALID only
// drops after a pop or a reset. The input side has no backpressure:
// IN_FRAME_READY is a single-cycle pulse, and a pulse that finds the buffer
// FULL (with no pop on the same edge) is dropped and flagged on OVERFLOW.
//
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   IN_DATA_FRAME         frame bytes, byte n at bits [8n+7:8n]
//   IN_SRC_IP_ADDRESS     sender IPv4 address
//   IN_SRC_MAC_ADDRESS    sender MAC address
//   IN_FRAME_READY        one-cycle pulse, inputs valid only in that cycle
//   OUT_DATA_FRAME        head-entry frame
//   OUT_METADATA          last byte (USER_DATA_BYTES-1) of head-entry frame
//   OUT_SRC_IP_ADDRESS    head-entry sender IP
//   OUT_SRC_MAC_ADDRESS   head-entry sender MAC
//   OUT_VALID / OUT_READY head-entry handshake
//   OCCUPANCY             number of stored frames
//   OVERFLOW              registered one-cycle pulse per dropped frame
//   DROP_COUNT            saturating dropped-frame counter
//   OCC_STATE             occupancy state (0 EMPTY, 1 HOLDING, 2 FULL)
//
// Build option: define FRAME_BUFFER_DROP_COUNT_EN to build the DROP_COUNT
// register; otherwise DROP_COUNT is tied to zero (OVERFLOW is always built).
// ---------------------------------------------------------------------------
module inference_frame_buffer #(
    parameter int USER_DATA_BYTES = 785,
    parameter int DEPTH           = 2
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [USER_DATA_BYTES*8-1:0] IN_DATA_FRAME,
    input  logic [31:0]                  IN_SRC_IP_ADDRESS,
    input  logic [47:0]                  IN_SRC_MAC_ADDRESS,
    input  logic                         IN_FRAME_READY,
    output logic [USER_DATA_BYTES*8-1:0] OUT_DATA_FRAME,
    output logic [7:0]                   OUT_METADATA,
    output logic [31:0]                  OUT_SRC_IP_ADDRESS,
    output logic [47:0]                  OUT_SRC_MAC_ADDRESS,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [$clog2(DEPTH):0]       OCCUPANCY,
    output logic                         OVERFLOW,
    output logic [15:0]                  DROP_COUNT,
    output logic [1:0]                   OCC_STATE
);

    localparam int FW    = USER_DATA_BYTES * 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_HOLDING = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

    occ_state_t        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic              overflow_q;
    logic              pop, push_ok, reject;

    logic [FW-1:0]     frame_mem [DEPTH];
    logic [31:0]       ip_mem    [DEPTH];
    logic [47:0]       mac_mem   [DEPTH];

    // Next-state / handshake decode. A push into a FULL buffer is still
    // accepted when the head leaves on the same edge.
    always_comb begin
        pop     = 1'b0;
        push_ok = 1'b0;
        reject  = 1'b0;
        count_d = count_q;
        state_d = state_q;

        pop     = (state_q != OCC_EMPTY) && OUT_READY;
        push_ok = IN_FRAME_READY && ((state_q != OCC_FULL) || pop);
        reject  = IN_FRAME_READY && !push_ok;

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (count_d == '0)
            state_d = OCC_EMPTY;
        else if (count_d == CNT_W'(DEPTH))
            state_d = OCC_FULL;
        else
            state_d = OCC_HOLDING;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= OCC_EMPTY;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= reject;
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                frame_mem[i] <= '0;
                ip_mem[i]    <= '0;
                mac_mem[i]   <= '0;
            end
        end else if (push_ok) begin
            frame_mem[wr_ptr_q] <= IN_DATA_FRAME;
            ip_mem[wr_ptr_q]    <= IN_SRC_IP_ADDRESS;
            mac_mem[wr_ptr_q]   <= IN_SRC_MAC_ADDRESS;
        end
    end

`ifdef FRAME_BUFFER_DROP_COUNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            drop_q <= 16'h0000;
        else if (reject && (drop_q != 16'hFFFF))
            drop_q <= drop_q + 16'd1;
    end

    assign DROP_COUNT = drop_q;
`else
    assign DROP_COUNT = 16'h0000;
`endif

    // No bypass: the head is always read from storage, so a frame pushed
    // into an empty buffer becomes visible one edge later.
    assign OUT_DATA_FRAME      = frame_mem[rd_ptr_q];
    assign OUT_METADATA        = frame_mem[rd_ptr_q][FW-1 -: 8];
    assign OUT_SRC_IP_ADDRESS  = ip_mem[rd_ptr_q];
    assign OUT_SRC_MAC_ADDRESS = mac_mem[rd_ptr_q];
    assign OUT_VALID           = (state_q != OCC_EMPTY);
    assign OCCUPANCY           = count_q;
    assign OVERFLOW            = overflow_q;
    assign OCC_STATE           = state_q;

endmodule

// File: doc/inference_frame_buffer.md
# inference_frame_buffer

Buffers complete inference frames emitted by the IP receive stage and hands them to the accelerator core over a valid/ready handshake. The receive stage's FRAME_READY is a one-cycle pulse with no backpressure, and its DATA_FRAME register is overwritten by the next packet's bytes. This block therefore captures the frame and source addresses on the pulse cycle and holds them until the accelerator accepts them. It also counts frames dropped because the buffer was full.

## Interface
Parameters:
- USER_DATA_BYTES, 785: frame size in bytes (784 pixels + 1 metadata byte).
- DEPTH, 2: number of frame entries; power of two, ≥2.

Ports:
- ACLK  in  1  clock; one clock, all logic on rising edge.
- ARESET  in  1  reset; asynchronous and active-high.
- IN_DATA_FRAME  in  USER_DATA_BYTES*8  frame from receive stage; byte n at bits [8n+7:8n].
- IN_SRC_IP_ADDRESS  in  32  sender IP of the frame.
- IN_SRC_MAC_ADDRESS  in  48  sender MAC of the frame.
- IN_FRAME_READY  in  1  single-cycle pulse; inputs valid only in this cycle.
- OUT_DATA_FRAME  out  USER_DATA_BYTES*8  head-entry frame.
- OUT_METADATA  out  8  byte USER_DATA_BYTES-1 of head-entry frame.
- OUT_SRC_IP_ADDRESS  out  32  head-entry sender IP.
- OUT_SRC_MAC_ADDRESS  out  48  head-entry sender MAC.
- OUT_VALID  out  1  head entry holds a frame.
- OUT_READY  in  1  accelerator accepts head frame.
- OCCUPANCY  out  $clog2(DEPTH)+1  stored frame count.
- OVERFLOW  out  1  one-cycle pulse, frame dropped.
- DROP_COUNT  out  16  saturating dropped-frame count.

## Operation
- Circular storage of DEPTH entries, each holding frame, IP and MAC.
- Write pointer, read pointer and count registers; pointers wrap modulo DEPTH.
- Occupancy states:
  - EMPTY: count 0.
  - HOLDING: 0 < count < DEPTH.
  - FULL: count == DEPTH.
- push = IN_FRAME_READY, accepted when not FULL, or when FULL with pop in the same cycle.
- pop = OUT_VALID && OUT_READY.
- Accepted push: the entry at the write pointer captures all three inputs at that edge, then the write pointer increments.
- Pop: the read pointer increments.
- Count update: push only +1; pop only −1; push and pop together, unchanged.
- Rejected push (FULL, no pop): inputs discarded and no pointer moves. OVERFLOW=1 next cycle. DROP_COUNT += 1, saturating at 16'hFFFF.
- Outputs are taken from the entry at the read pointer. OUT_VALID = (count != 0).
- IN_FRAME_READY in consecutive cycles is legal; each pulse is a distinct frame.

## Timing
- Reset: all outputs 0, entries 0, pointers 0, count 0, DROP_COUNT 0.
- Reset asserted mid-operation discards all stored frames immediately (asynchronous).
- Latency: a frame pushed at edge k gives OUT_VALID=1 after edge k when the buffer was EMPTY. That frame's data appears on OUT_* from the same edge.
- Handshake:
  - While OUT_VALID=1 and OUT_READY=0, OUT_* hold stable.
  - OUT_VALID never drops without a pop or a reset.
  - OUT_READY while OUT_VALID=0 has no effect.
- Push when EMPTY with OUT_READY=1: no same-cycle bypass; the frame becomes visible next cycle.
- Wrap: after DEPTH pushes and pops, the pointers return to 0 and order is preserved (FIFO).
- OVERFLOW is registered, high exactly one cycle per rejected push.

## Configuration
- FRAME_BUFFER_DROP_COUNT_EN defined: the DROP_COUNT register and its saturation logic are built.
- FRAME_BUFFER_DROP_COUNT_EN undefined: DROP_COUNT is tied to 16'h0000. OVERFLOW is still generated.

## Test plan
- Single frame: reset, push frame with byte0=0x11, metadata 0x07, IP 0x0A000002, OUT_READY=0 → next cycle OUT_VALID=1, OUT_METADATA=0x07, OUT_SRC_IP_ADDRESS=0x0A000002, OCCUPANCY=1; held 10 cycles; OUT_READY=1 one cycle → OUT_VALID=0, OCCUPANCY=0.
- Order and wrap: DEPTH=2, push frames A, B, pop A, push C, pop B, pop C → outputs A, B, C in order; pointers wrap, OCCUPANCY sequence 1,2,1,2,1,0.
- Overflow: fill 2 entries, OUT_READY=0, push D → OVERFLOW pulse 1 cycle, DROP_COUNT=1, head still A; push with OUT_READY=1 while FULL → accepted, OCCUPANCY stays 2, OVERFLOW=0.
- Saturation: with FRAME_BUFFER_DROP_COUNT_EN, force 65540 rejected pushes → DROP_COUNT=16'hFFFF; without macro → DROP_COUNT=0 throughout.
- Back-to-back: pulses on 3 consecutive cycles, DEPTH=4, OUT_READY=0 → OCCUPANCY=3, frames drain in input order.
- Reset mid-operation: 2 frames stored, assert ARESET between edges → OUT_VALID=0, OCCUPANCY=0, DROP_COUNT=0 immediately; first post-reset push appears as head.
